decode_cycle: RTL
=================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL provide i_decode_clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL provide i_decode_reset, input, 1, synchronous active-high reset.
REQ-003 SHALL provide i_decode_pc, input, 32, PC of the instruction held in the IF/ID register.
REQ-004 SHALL provide i_decode_inst, input, 32, instruction held in the IF/ID register.
REQ-005 SHALL provide i_decode_flush, input, 1, branch/jump taken in Execute; kill the ID instruction.
REQ-006 SHALL provide i_ex_mem_read, input, 1, the instruction currently in Execute is a load.
REQ-007 SHALL provide i_ex_rd_addr, input, 5, destination register of the instruction in Execute.
REQ-008 SHALL provide i_wb_rd_wren, input, 1, register file write enable from Writeback.
REQ-009 SHALL provide i_wb_rd_addr, input, 5, register file write address from Writeback.
REQ-010 SHALL provide i_wb_rd_data, input, 32, register file write data from Writeback.
REQ-011 SHALL provide o_stall, output, 1, load-use hazard; drives the IF stage stall input (holds PC and IF/ID).
REQ-012 SHALL provide the following ID/EX register outputs: o_decode_pc_ex (32), o_decode_inst_ex (32), o_decode_rs1_data (32), o_decode_rs2_data (32), o_decode_imm (32), o_decode_rd_addr (5), o_decode_rd_wren (1), o_decode_mem_read (1), o_decode_mem_write (1).

Function
REQ-013 SHALL hold a 32x32 register file; x0 SHALL read as 0 and SHALL ignore writes.
REQ-014 SHALL apply register file writes on the rising edge when i_wb_rd_wren=1 and i_wb_rd_addr!=0.
REQ-015 SHALL read rs1=inst[19:15] and rs2=inst[24:20] combinationally.
REQ-016 SHALL generate the sign-extended immediate by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits 0), J (1101111, bit0=0); all other opcodes produce 0.
REQ-017 SHALL set rd_wren=1 for opcodes 0110011, 0010011, 0000011, 1101111, 1100111, 0110111 and 0010111 when rd!=0; rd_wren SHALL be 0 otherwise.
REQ-018 SHALL set mem_read only for opcode 0000011 and mem_write only for opcode 0100011.
REQ-019 SHALL treat rs1 as used for every opcode except 0110111, 0010111 and 1101111, and SHALL treat rs2 as used only for 0110011, 0100011 and 1100011.
REQ-020 SHALL drive o_stall=1 combinationally when i_ex_mem_read=1, i_ex_rd_addr!=0, and i_ex_rd_addr equals a used rs1 or rs2, and i_decode_flush=0.
REQ-021 SHALL load the decoded instruction into ID/EX one cycle after it is presented, with latency 1, when there is no stall and no flush.
REQ-022 SHALL load a bubble into ID/EX when o_stall=1: inst 0x00000013, rd_wren/mem_read/mem_write=0, rd_addr=0, imm=0, data=0, pc passed through.
REQ-023 SHALL load a bubble into ID/EX when i_decode_flush=1, regardless of any hazard; flush has priority and forces o_stall=0.
REQ-024 SHALL let synchronous reset override flush, stall and register file writes in the same cycle.

Reset
REQ-025 SHALL, on a reset edge, clear o_decode_pc_ex, rs1/rs2 data, imm, rd_addr and all control outputs to 0, and set o_decode_inst_ex=0x00000013.
REQ-026 SHALL clear all 32 register file entries to 0 on the reset edge.
REQ-027 SHALL hold o_stall at 0 while i_decode_reset=1.

Configuration
REQ-028 SHALL, when DECODE_WB_BYPASS_EN is defined, forward i_wb_rd_data to the rs1/rs2 data on a same-cycle address match (wren=1, addr!=0).
REQ-029 SHALL, when DECODE_WB_BYPASS_EN is undefined, return the pre-write register file contents for a same-cycle address match; hazard logic is unchanged in this case.

Verification
REQ-030 SHALL be verified by scenario 1: reset for 2 cycles -> all outputs 0, o_decode_inst_ex=0x00000013, o_stall=0, and reads of x1..x31 return 0.
REQ-031 SHALL be verified by scenario 2: write x5=0xDEADBEEF, then present add x6,x5,x5 (0x00528333) -> next cycle rs1/rs2 data=0xDEADBEEF, rd_addr=6, rd_wren=1.
REQ-032 SHALL be verified by scenario 3: i_ex_mem_read=1, i_ex_rd_addr=5, inst 0x00528333 -> o_stall=1 and ID/EX=bubble; with i_ex_rd_addr=0 -> o_stall=0.
REQ-033 SHALL be verified by scenario 4: hazard condition plus i_decode_flush=1 -> o_stall=0 and ID/EX=bubble.
REQ-034 SHALL be verified by scenario 5: sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, mem_write=1, rd_wren=0; jal x1,-8 (0xFF9FF0EF) -> imm=0xFFFFFFF8.
REQ-035 SHALL be verified by scenario 6: WB writes x7=0x1234 while inst reads x7 -> rs1 data=0x1234 with DECODE_WB_BYPASS_EN, and the old value without it; a write to x0 leaves x0 reading 0.

Source files
------------

// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle -- RV32I instruction decode stage with ID/EX pipeline register.
//
// Decodes the instruction in the IF/ID register, reads rs1/rs2 from a 32x32
// register file, builds the sign-extended immediate and control bits, and
// detects the load-use hazard. The result is registered into ID/EX. A bubble
// (addi x0,x0,0 with all control cleared) replaces the instruction on a stall
// or flush.
//
// Ports:
//   i_decode_clk       clock; all state updates on the rising edge
//   i_decode_reset     synchronous active-high reset
//   i_decode_pc        PC of the instruction in IF/ID
//   i_decode_inst      instruction in IF/ID
//   i_decode_flush     branch/jump taken in Execute; kill the ID instruction
//   i_ex_mem_read      instruction in Execute is a load
//   i_ex_rd_addr       destination register of the instruction in Execute
//   i_wb_rd_wren       register file write enable from Writeback
//   i_wb_rd_addr       register file write address from Writeback
//   i_wb_rd_data       register file write data from Writeback
//   o_stall            load-use hazard; holds PC and IF/ID
//   o_decode_*         ID/EX register contents
//
// Configuration:
//   DECODE_WB_BYPASS_EN  when defined, a Writeback write to the register being
//                        read in the same cycle is forwarded to the read data.
//                        When undefined, the pre-write contents are returned.
// -----------------------------------------------------------------------------
module decode_cycle (
  input  logic        i_decode_clk,
  input  logic        i_decode_reset,
  input  logic [31:0] i_decode_pc,
  input  logic [31:0] i_decode_inst,
  input  logic        i_decode_flush,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_wb_rd_wren,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic [31:0] i_wb_rd_data,
  output logic        o_stall,
  output logic [31:0] o_decode_pc_ex,
  output logic [31:0] o_decode_inst_ex,
  output logic [31:0] o_decode_rs1_data,
  output logic [31:0] o_decode_rs2_data,
  output logic [31:0] o_decode_imm,
  output logic [4:0]  o_decode_rd_addr,
  output logic        o_decode_rd_wren,
  output logic        o_decode_mem_read,
  output logic        o_decode_mem_write
);

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  // Field decode
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = i_decode_inst[6:0];
  assign rd     = i_decode_inst[11:7];
  assign rs1    = i_decode_inst[19:15];
  assign rs2    = i_decode_inst[24:20];

  // State
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  id_ex_t      id_ex_q;
  id_ex_t      id_ex_d;

  // Combinational decode results
  logic [31:0] imm;
  logic        rd_wren;
  logic        mem_read;
  logic        mem_write;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;

  // Immediate generation and control decode
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    imm       = '0;
    rd_wren   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;

    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{i_decode_inst[31]}}, i_decode_inst[31:20]};
      OP_STORE:
        imm = {{20{i_decode_inst[31]}}, i_decode_inst[31:25], i_decode_inst[11:7]};
      OP_BRANCH:
        imm = {{19{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[7],
               i_decode_inst[30:25], i_decode_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {i_decode_inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[19:12],
               i_decode_inst[20], i_decode_inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase

    unique case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
        rd_wren = (rd != 5'd0);
      default:
        rd_wren = 1'b0;
    endcase

    mem_read  = (opcode == OP_LOAD);
    mem_write = (opcode == OP_STORE);

    // LUI/AUIPC/JAL carry immediate bits in the rs1 field; only R, S and B
    // formats actually source rs2.
    rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  // Register file read, with optional same-cycle Writeback bypass
  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (i_wb_rd_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs1)) begin
      rs1_data = i_wb_rd_data;
    end
    if (i_wb_rd_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs2)) begin
      rs2_data = i_wb_rd_data;
    end
`else
    // Reads see the pre-write contents; the write lands on the same edge that
    // captures the read data into ID/EX.
`endif
  end

  // Load-use hazard. Flush and reset both suppress it: a flushed instruction
  // is discarded, so there is nothing to wait for.
  always_comb begin
    stall = 1'b0;
    if (!i_decode_reset && !i_decode_flush && i_ex_mem_read &&
        (i_ex_rd_addr != 5'd0)) begin
      stall = (rs1_used && (i_ex_rd_addr == rs1)) ||
              (rs2_used && (i_ex_rd_addr == rs2));
    end
  end

  assign o_stall = stall;

  // Next ID/EX contents: decoded instruction or bubble (pc still passes)
  always_comb begin
    id_ex_d.pc = i_decode_pc;
    if (stall || i_decode_flush) begin
      id_ex_d.inst      = NOP_INST;
      id_ex_d.rs1_data  = '0;
      id_ex_d.rs2_data  = '0;
      id_ex_d.imm       = '0;
      id_ex_d.rd_addr   = '0;
      id_ex_d.rd_wren   = 1'b0;
      id_ex_d.mem_read  = 1'b0;
      id_ex_d.mem_write = 1'b0;
    end else begin
      id_ex_d.inst      = i_decode_inst;
      id_ex_d.rs1_data  = rs1_data;
      id_ex_d.rs2_data  = rs2_data;
      id_ex_d.imm       = imm;
      id_ex_d.rd_addr   = rd;
      id_ex_d.rd_wren   = rd_wren;
      id_ex_d.mem_read  = mem_read;
      id_ex_d.mem_write = mem_write;
    end
  end

  // Next register file contents; x0 is never written
  always_comb begin
    regs_d = regs_q;
    if (i_wb_rd_wren && (i_wb_rd_addr != 5'd0)) begin
      regs_d[i_wb_rd_addr] = i_wb_rd_data;
    end
  end

  always_ff @(posedge i_decode_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_decode_reset) begin
      id_ex_q <= '{pc: '0, inst: NOP_INST, rs1_data: '0, rs2_data: '0,
                   imm: '0, rd_addr: '0, rd_wren: 1'b0, mem_read: 1'b0,
                   mem_write: 1'b0};
      // NOTE: the register file is cleared on reset, so it must be built
      // from flops rather than a RAM macro that cannot be reset in one edge.
      regs_q  <= '{default: '0};
    end else begin
      id_ex_q <= id_ex_d;
      regs_q  <= regs_d;
    end
  end

  assign o_decode_pc_ex     = id_ex_q.pc;
  assign o_decode_inst_ex   = id_ex_q.inst;
  assign o_decode_rs1_data  = id_ex_q.rs1_data;
  assign o_decode_rs2_data  = id_ex_q.rs2_data;
  assign o_decode_imm       = id_ex_q.imm;
  assign o_decode_rd_addr   = id_ex_q.rd_addr;
  assign o_decode_rd_wren   = id_ex_q.rd_wren;
  assign o_decode_mem_read  = id_ex_q.mem_read;
  assign o_decode_mem_write = id_ex_q.mem_write;

endmodule
